// File: rtl/aes_128_key.sv
// aes_128_key: AES-128 key expansion, producing round keys 0..10.
// Default build is iterative: one round key per clock using 4 shared S-boxes.
// Define AES_KEY_UNROLL_EN for a fully unrolled build that registers all keys at once.
module aes_128_key (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  aes_key_vld_i,
  input  logic [127:0]          aes_key_i,
  output logic [10:0][127:0]    aes_key_o,
  output logic                  aes_key_rdy_o
);

  function automatic logic [7:0] sbox(input logic [7:0] b);
    sbox = '0;
    case (b)
      8'h00: sbox = 8'h63; 8'h01: sbox = 8'h7c; 8'h02: sbox = 8'h77; 8'h03: sbox = 8'h7b; 8'h04: sbox = 8'hf2; 8'h05: sbox = 8'h6b; 8'h06: sbox = 8'h6f; 8'h07: sbox = 8'hc5;
      8'h08: sbox = 8'h30; 8'h09: sbox = 8'h01; 8'h0a: sbox = 8'h67; 8'h0b: sbox = 8'h2b; 8'h0c: sbox = 8'hfe; 8'h0d: sbox = 8'hd7; 8'h0e: sbox = 8'hab; 8'h0f: sbox = 8'h76;
      8'h10: sbox = 8'hca; 8'h11: sbox = 8'h82; 8'h12: sbox = 8'hc9; 8'h13: sbox = 8'h7d; 8'h14: sbox = 8'hfa; 8'h15: sbox = 8'h59; 8'h16: sbox = 8'h47; 8'h17: sbox = 8'hf0;
      8'h18: sbox = 8'had; 8'h19: sbox = 8'hd4; 8'h1a: sbox = 8'ha2; 8'h1b: sbox = 8'haf; 8'h1c: sbox = 8'h9c; 8'h1d: sbox = 8'ha4; 8'h1e: sbox = 8'h72; 8'h1f: sbox = 8'hc0;
      8'h20: sbox = 8'hb7; 8'h21: sbox = 8'hfd; 8'h22: sbox = 8'h93; 8'h23: sbox = 8'h26; 8'h24: sbox = 8'h36; 8'h25: sbox = 8'h3f; 8'h26: sbox = 8'hf7; 8'h27: sbox = 8'hcc;
      8'h28: sbox = 8'h34; 8'h29: sbox = 8'ha5; 8'h2a: sbox = 8'he5; 8'h2b: sbox = 8'hf1; 8'h2c: sbox = 8'h71; 8'h2d: sbox = 8'hd8; 8'h2e: sbox = 8'h31; 8'h2f: sbox = 8'h15;
      8'h30: sbox = 8'h04; 8'h31: sbox = 8'hc7; 8'h32: sbox = 8'h23; 8'h33: sbox = 8'hc3; 8'h34: sbox = 8'h18; 8'h35: sbox = 8'h96; 8'h36: sbox = 8'h05; 8'h37: sbox = 8'h9a;
      8'h38: sbox = 8'h07; 8'h39: sbox = 8'h12; 8'h3a: sbox = 8'h80; 8'h3b: sbox = 8'he2; 8'h3c: sbox = 8'heb; 8'h3d: sbox = 8'h27; 8'h3e: sbox = 8'hb2; 8'h3f: sbox = 8'h75;
      8'h40: sbox = 8'h09; 8'h41: sbox = 8'h83; 8'h42: sbox = 8'h2c; 8'h43: sbox = 8'h1a; 8'h44: sbox = 8'h1b; 8'h45: sbox = 8'h6e; 8'h46: sbox = 8'h5a; 8'h47: sbox = 8'ha0;
      8'h48: sbox = 8'h52; 8'h49: sbox = 8'h3b; 8'h4a: sbox = 8'hd6; 8'h4b: sbox = 8'hb3; 8'h4c: sbox = 8'h29; 8'h4d: sbox = 8'he3; 8'h4e: sbox = 8'h2f; 8'h4f: sbox = 8'h84;
      8'h50: sbox = 8'h53; 8'h51: sbox = 8'hd1; 8'h52: sbox = 8'h00; 8'h53: sbox = 8'hed; 8'h54: sbox = 8'h20; 8'h55: sbox = 8'hfc; 8'h56: sbox = 8'hb1; 8'h57: sbox = 8'h5b;
      8'h58: sbox = 8'h6a; 8'h59: sbox = 8'hcb; 8'h5a: sbox = 8'hbe; 8'h5b: sbox = 8'h39; 8'h5c: sbox = 8'h4a; 8'h5d: sbox = 8'h4c; 8'h5e: sbox = 8'h58; 8'h5f: sbox = 8'hcf;
      8'h60: sbox = 8'hd0; 8'h61: sbox = 8'hef; 8'h62: sbox = 8'haa; 8'h63: sbox = 8'hfb; 8'h64: sbox = 8'h43; 8'h65: sbox = 8'h4d; 8'h66: sbox = 8'h33; 8'h67: sbox = 8'h85;
      8'h68: sbox = 8'h45; 8'h69: sbox = 8'hf9; 8'h6a: sbox = 8'h02; 8'h6b: sbox = 8'h7f; 8'h6c: sbox = 8'h50; 8'h6d: sbox = 8'h3c; 8'h6e: sbox = 8'h9f; 8'h6f: sbox = 8'ha8;
      8'h70: sbox = 8'h51; 8'h71: sbox = 8'ha3; 8'h72: sbox = 8'h40; 8'h73: sbox = 8'h8f; 8'h74: sbox = 8'h92; 8'h75: sbox = 8'h9d; 8'h76: sbox = 8'h38; 8'h77: sbox = 8'hf5;
      8'h78: sbox = 8'hbc; 8'h79: sbox = 8'hb6; 8'h7a: sbox = 8'hda; 8'h7b: sbox = 8'h21; 8'h7c: sbox = 8'h10; 8'h7d: sbox = 8'hff; 8'h7e: sbox = 8'hf3; 8'h7f: sbox = 8'hd2;
      8'h80: sbox = 8'hcd; 8'h81: sbox = 8'h0c; 8'h82: sbox = 8'h13; 8'h83: sbox = 8'hec; 8'h84: sbox = 8'h5f; 8'h85: sbox = 8'h97; 8'h86: sbox = 8'h44; 8'h87: sbox = 8'h17;
      8'h88: sbox = 8'hc4; 8'h89: sbox = 8'ha7; 8'h8a: sbox = 8'h7e; 8'h8b: sbox = 8'h3d; 8'h8c: sbox = 8'h64; 8'h8d: sbox = 8'h5d; 8'h8e: sbox = 8'h19; 8'h8f: sbox = 8'h73;
      8'h90: sbox = 8'h60; 8'h91: sbox = 8'h81; 8'h92: sbox = 8'h4f; 8'h93: sbox = 8'hdc; 8'h94: sbox = 8'h22; 8'h95: sbox = 8'h2a; 8'h96: sbox = 8'h90; 8'h97: sbox = 8'h88;
      8'h98: sbox = 8'h46; 8'h99: sbox = 8'hee; 8'h9a: sbox = 8'hb8; 8'h9b: sbox = 8'h14; 8'h9c: sbox = 8'hde; 8'h9d: sbox = 8'h5e; 8'h9e: sbox = 8'h0b; 8'h9f: sbox = 8'hdb;
      8'ha0: sbox = 8'he0; 8'ha1: sbox = 8'h32; 8'ha2: sbox = 8'h3a; 8'ha3: sbox = 8'h0a; 8'ha4: sbox = 8'h49; 8'ha5: sbox = 8'h06; 8'ha6: sbox = 8'h24; 8'ha7: sbox = 8'h5c;
      8'ha8: sbox = 8'hc2; 8'ha9: sbox = 8'hd3; 8'haa: sbox = 8'hac; 8'hab: sbox = 8'h62; 8'hac: sbox = 8'h91; 8'had: sbox = 8'h95; 8'hae: sbox = 8'he4; 8'haf: sbox = 8'h79;
      8'hb0: sbox = 8'he7; 8'hb1: sbox = 8'hc8; 8'hb2: sbox = 8'h37; 8'hb3: sbox = 8'h6d; 8'hb4: sbox = 8'h8d; 8'hb5: sbox = 8'hd5; 8'hb6: sbox = 8'h4e; 8'hb7: sbox = 8'ha9;
      8'hb8: sbox = 8'h6c; 8'hb9: sbox = 8'h56; 8'hba: sbox = 8'hf4; 8'hbb: sbox = 8'hea; 8'hbc: sbox = 8'h65; 8'hbd: sbox = 8'h7a; 8'hbe: sbox = 8'hae; 8'hbf: sbox = 8'h08;
      8'hc0: sbox = 8'hba; 8'hc1: sbox = 8'h78; 8'hc2: sbox = 8'h25; 8'hc3: sbox = 8'h2e; 8'hc4: sbox = 8'h1c; 8'hc5: sbox = 8'ha6; 8'hc6: sbox = 8'hb4; 8'hc7: sbox = 8'hc6;
      8'hc8: sbox = 8'he8; 8'hc9: sbox = 8'hdd; 8'hca: sbox = 8'h74; 8'hcb: sbox = 8'h1f; 8'hcc: sbox = 8'h4b; 8'hcd: sbox = 8'hbd; 8'hce: sbox = 8'h8b; 8'hcf: sbox = 8'h8a;
      8'hd0: sbox = 8'h70; 8'hd1: sbox = 8'h3e; 8'hd2: sbox = 8'hb5; 8'hd3: sbox = 8'h66; 8'hd4: sbox = 8'h48; 8'hd5: sbox = 8'h03; 8'hd6: sbox = 8'hf6; 8'hd7: sbox = 8'h0e;
      8'hd8: sbox = 8'h61; 8'hd9: sbox = 8'h35; 8'hda: sbox = 8'h57; 8'hdb: sbox = 8'hb9; 8'hdc: sbox = 8'h86; 8'hdd: sbox = 8'hc1; 8'hde: sbox = 8'h1d; 8'hdf: sbox = 8'h9e;
      8'he0: sbox = 8'he1; 8'he1: sbox = 8'hf8; 8'he2: sbox = 8'h98; 8'he3: sbox = 8'h11; 8'he4: sbox = 8'h69; 8'he5: sbox = 8'hd9; 8'he6: sbox = 8'h8e; 8'he7: sbox = 8'h94;
      8'he8: sbox = 8'h9b; 8'he9: sbox = 8'h1e; 8'hea: sbox = 8'h87; 8'heb: sbox = 8'he9; 8'hec: sbox = 8'hce; 8'hed: sbox = 8'h55; 8'hee: sbox = 8'h28; 8'hef: sbox = 8'hdf;
      8'hf0: sbox = 8'h8c; 8'hf1: sbox = 8'ha1; 8'hf2: sbox = 8'h89; 8'hf3: sbox = 8'h0d; 8'hf4: sbox = 8'hbf; 8'hf5: sbox = 8'he6; 8'hf6: sbox = 8'h42; 8'hf7: sbox = 8'h68;
      8'hf8: sbox = 8'h41; 8'hf9: sbox = 8'h99; 8'hfa: sbox = 8'h2d; 8'hfb: sbox = 8'h0f; 8'hfc: sbox = 8'hb0; 8'hfd: sbox = 8'h54; 8'hfe: sbox = 8'hbb; 8'hff: sbox = 8'h16;
    endcase
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    rcon = '0;
    case (r)
      4'd1: rcon = 8'h01; 4'd2: rcon = 8'h02; 4'd3: rcon = 8'h04; 4'd4: rcon = 8'h08; 4'd5: rcon = 8'h10;
      4'd6: rcon = 8'h20; 4'd7: rcon = 8'h40; 4'd8: rcon = 8'h80; 4'd9: rcon = 8'h1b; 4'd10: rcon = 8'h36;
      default: rcon = '0;
    endcase
  endfunction

  // One expansion round: 4 S-box lookups on RotWord of the last word, then the xor chain.
  function automatic logic [127:0] expand(input logic [127:0] prev, input logic [7:0] rc);
    logic [31:0] t, w0, w1, w2, w3;
    t  = {sbox(prev[23:16]), sbox(prev[15:8]), sbox(prev[7:0]), sbox(prev[31:24])} ^ {rc, 24'h0};
    w0 = prev[127:96] ^ t;
    w1 = prev[95:64]  ^ w0;
    w2 = prev[63:32]  ^ w1;
    w3 = prev[31:0]   ^ w2;
    expand = {w0, w1, w2, w3};
  endfunction

`ifdef AES_KEY_UNROLL_EN

  function automatic logic [10:0][127:0] expand_all(input logic [127:0] key);
    logic [10:0][127:0] chain;
    chain[0] = key;
    for (int unsigned i = 1; i < 11; i++)
      chain[i] = expand(chain[i-1], rcon(4'(i)));
    expand_all = chain;
  endfunction

  logic [10:0][127:0] all_keys;

  // Full combinational chain from the incoming key.
  always_comb all_keys = expand_all(aes_key_i);

  // Register every round key on the capture edge; ready immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aes_key_o     <= '0;
      aes_key_rdy_o <= 1'b0;
    end else if (aes_key_vld_i) begin
      aes_key_o     <= all_keys;
      aes_key_rdy_o <= 1'b1;
    end
  end

`else

  typedef enum logic {IDLE, BUSY} state_t;

  state_t       state_q, state_d;
  logic [3:0]   cnt_q;
  logic [127:0] prev_key, next_key;

  // Next state, and the round computed from the previously written key.
  always_comb begin
    state_d  = state_q;
    prev_key = '0;
    for (int unsigned i = 1; i < 11; i++)
      if (cnt_q == 4'(i)) prev_key = aes_key_o[i-1];
    next_key = expand(prev_key, rcon(cnt_q));
    if (aes_key_vld_i)
      state_d = BUSY;
    else if (state_q == BUSY && cnt_q == 4'd10)
      state_d = IDLE;
  end

  // State, round counter, round-key storage and ready flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      aes_key_o     <= '0;
      aes_key_rdy_o <= 1'b0;
    end else begin
      state_q <= state_d;
      if (aes_key_vld_i) begin
        aes_key_o     <= '0;
        aes_key_o[0]  <= aes_key_i;
        aes_key_rdy_o <= 1'b0;
        cnt_q         <= 4'd1;
      end else if (state_q == BUSY) begin
        for (int unsigned i = 1; i < 11; i++)
          if (cnt_q == 4'(i)) aes_key_o[i] <= next_key;
        cnt_q <= cnt_q + 4'd1;
        if (cnt_q == 4'd10) aes_key_rdy_o <= 1'b1;
      end
    end
  end

`endif

endmodule

// File: tb/tb_aes_128_key.sv
// tb_aes_128_key: directed tests of aes_128_key against FIPS-197 constants and a word-wise reference model.
module tb_aes_128_key;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               vld = 1'b0;
  logic [127:0]       key_i = '0;
  logic [10:0][127:0] key_o;
  logic               rdy;

  int checks = 0;
  int errors = 0;

`ifdef AES_KEY_UNROLL_EN
  localparam int EXP_LAT = 0;
`else
  localparam int EXP_LAT = 10;
`endif

  localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KEY_2    = 128'h8f6f462518ab4e98b9d4114820276c41;
  localparam logic [127:0] KEY_B    = 128'h000102030405060708090a0b0c0d0e0f;

  logic [2047:0] sbox_tbl = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  aes_128_key dut (
    .clk           (clk),
    .rst           (rst),
    .aes_key_vld_i (vld),
    .aes_key_i     (key_i),
    .aes_key_o     (key_o),
    .aes_key_rdy_o (rdy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] ref_sub(input logic [7:0] b);
    ref_sub = sbox_tbl[2047 - 8 * int'(b) -: 8];
  endfunction

  // Word-indexed expansion w[0..43]; round constants generated by repeated xtime.
  function automatic logic [10:0][127:0] ref_expand(input logic [127:0] k);
    logic [31:0] w [44];
    logic [31:0] tmp;
    logic [7:0]  rc;
    logic [10:0][127:0] r;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {ref_sub(tmp[23:16]), ref_sub(tmp[15:8]), ref_sub(tmp[7:0]), ref_sub(tmp[31:24])} ^ {rc, 24'h0};
        rc  = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 11; i++) r[i] = {w[4*i], w[4*i+1], w[4*i+2], w[4*i+3]};
    ref_expand = r;
  endfunction

  task automatic strobe(input logic [127:0] k);
    @(negedge clk);
    vld   = 1'b1;
    key_i = k;
    @(negedge clk);
    vld   = 1'b0;
  endtask

  task automatic wait_rdy(output int lat);
    lat = 0;
    while (rdy !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic check_all(input string tag, input logic [127:0] k);
    logic [10:0][127:0] exp;
    exp = ref_expand(k);
    for (int i = 0; i < 11; i++) check($sformatf("%s key%0d", tag, i), key_o[i], exp[i]);
  endtask

  task automatic check_zero(input string tag);
    for (int i = 0; i < 11; i++) check($sformatf("%s key%0d", tag, i), key_o[i], '0);
    check({tag, " rdy"}, 128'(rdy), '0);
  endtask

  initial begin
    int lat;

    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;

    strobe(FIPS_KEY);
    check("fips cap key0", key_o[0], FIPS_KEY);
`ifndef AES_KEY_UNROLL_EN
    check("fips cap rdy", 128'(rdy), '0);
    for (int i = 1; i < 11; i++) check($sformatf("fips cleared key%0d", i), key_o[i], '0);
`endif
    wait_rdy(lat);
    check("fips latency", 128'(lat), 128'(EXP_LAT));
    check("fips key1", key_o[1], 128'ha0fafe1788542cb123a339392a6c7605);
    check("fips key10", key_o[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    check_all("fips", FIPS_KEY);

    strobe(KEY_2);
    check("k2 cap key0", key_o[0], KEY_2);
    wait_rdy(lat);
    check("k2 latency", 128'(lat), 128'(EXP_LAT));
    check_all("k2", KEY_2);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      check_all($sformatf("k2 hold%0d", c), KEY_2);
      check($sformatf("k2 hold%0d rdy", c), 128'(rdy), 128'd1);
    end

    strobe(FIPS_KEY);
    repeat (3) @(negedge clk);
`ifndef AES_KEY_UNROLL_EN
    check("restart pre rdy", 128'(rdy), '0);
`endif
    strobe(KEY_B);
    check("restart cap key0", key_o[0], KEY_B);
    wait_rdy(lat);
    check("restart latency", 128'(lat), 128'(EXP_LAT));
    check_all("restart", KEY_B);

    strobe('0);
    wait_rdy(lat);
    check("zero latency", 128'(lat), 128'(EXP_LAT));
    check("zero key1", key_o[1], 128'h62636363626363636263636362636363);
    check("zero key10", key_o[10], 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

    strobe(KEY_2);
    repeat (4) @(negedge clk);
    #2 rst = 1'b1;
    #1 check_zero("midreset");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_zero("post reset");
    strobe(FIPS_KEY);
    wait_rdy(lat);
    check("after reset latency", 128'(lat), 128'(EXP_LAT));
    check("after reset key10", key_o[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    check_all("after reset", FIPS_KEY);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
